evr_marker_decoder: RTL and testbench
=====================================

Name: evr_marker_decoder

Overview:
Decodes the EVR event-code stream in the evrClk domain and drives the two marker inputs of the SROC generator: heartbeat and pulse-per-second.
- Each marker is stretched to a fixed width so the sysClk-domain watchdogs can sample it reliably.
- Also recovers the EVR seconds/ticks timestamp from the distributed shift events, for time-tagging downstream acquisitions.

Parameters:
MARKER_WIDTH, 8, evrClk cycles each marker stays high; legal range 2..255.
TICKS_WIDTH, 32, width of the evrClk tick counter.

Ports:
evrClk  input  1  EVR recovered clock; sole clock.
evrRst_n  input  1  asynchronous active-low reset.
evrEventCode  input  8  received event code, one per evrClk; 0x00 = no event.
heartbeatCode  input  8  event code treated as heartbeat; quasi-static; 0 disables.
ppsCode  input  8  event code treated as pulse-per-second; quasi-static; 0 disables.
evrHeartbeatMarker  output  1  stretched heartbeat marker.
evrPulsePerSecondMarker  output  1  stretched PPS marker.
evrSeconds  output  32  seconds value latched at the last PPS.
evrTicks  output  TICKS_WIDTH  evrClk cycles since the last PPS.
evrTimestampValid  output  1  evrSeconds is trustworthy.
evrTimestampStrobe  output  1  one-cycle pulse when evrSeconds updates.

Behaviour:
- Reset: all outputs, counters, shift register and bit count go to 0 asynchronously. Release is synchronous to evrClk.
- Input register: evrEventCode is registered once (codeQ); all decode works on codeQ.
- Match rule:
  - hbHit = (codeQ == heartbeatCode) && (heartbeatCode != 0).
  - ppsHit is defined the same way using ppsCode.
  - If both codes are equal and nonzero, both hit in the same cycle.
- Marker stretcher, one per marker, each with an 8-bit down-counter:
  - On a hit the counter loads MARKER_WIDTH and the marker goes high on the next edge.
  - A code arriving at the input at edge N gives a marker high for edges N+2 .. N+1+MARKER_WIDTH.
  - Marker = (counter != 0), registered.
  - A hit while already stretched reloads the counter: the marker stays high with no low gap, and the width is extended.
- Shift register, 32 bits, MSB first:
  - Code 0x70 does shiftReg <= {shiftReg[30:0],0}; code 0x71 shifts in 1.
  - Each shift increments bitCount, a 6-bit counter saturating at 32.
- On ppsHit:
  - evrSeconds <= shiftReg; evrTicks <= 0; shiftReg <= 0; bitCount <= 0; evrTimestampStrobe <= 1 for one cycle.
  - evrTimestampValid <= (bitCount == 32). A PPS that follows a short or absent shift sequence clears valid.
  - A shift code arriving in the same cycle as the PPS is impossible, since there is one code per cycle.
- Ticks: otherwise evrTicks increments every cycle and saturates at all-ones; saturation also clears evrTimestampValid.
- Codes 0x70/0x71 are still consumed by the shift register if they are also programmed as heartbeatCode or ppsCode.
- Changing heartbeatCode/ppsCode mid-stream takes effect on the next codeQ comparison. No glitch protection is required; software changes codes only while markers are idle.

Optional Feature:
EVR_MARKER_HOLDOFF_EN:
- When defined, each marker uses a 16-bit holdoff counter that loads 0xFFFF on every accepted hit and counts down to 0.
- While holdoff != 0, further hits for that marker are ignored: no reload and no retrigger.
- This suppresses event-code glitches near a genuine heartbeat. Holdoff resets to 0.
- When undefined, the retrigger/reload behaviour above applies and no holdoff logic is built.

Decomposition:
- Package evr_marker_pkg holds:
  - constants EVR_CODE_NULL=8'h00, EVR_CODE_SHIFT0=8'h70, EVR_CODE_SHIFT1=8'h71, EVR_CODE_SECONDS_DEFAULT=8'h7D;
  - localparam SECONDS_BITS=32.
- One sub-module, evr_marker_stretcher (hit in, marker out, width counter, optional holdoff), instantiated twice.
- Shift and tick logic stays in the top level.

Test Plan:
- Heartbeat: heartbeatCode=0x7A, MARKER_WIDTH=8, single 0x7A at edge 10 -> evrHeartbeatMarker high on edges 12..19, low at 20.
- Retrigger: 0x7A at edges 10 and 14 -> marker continuously high edges 12..23. With EVR_MARKER_HOLDOFF_EN defined, high 12..19 only.
- Timestamp: shift the 32 codes encoding 0x12345678 MSB first, then 0x7D with ppsCode=0x7D -> evrSeconds=0x12345678, evrTimestampStrobe one cycle, evrTimestampValid=1, evrTicks=0 then incrementing.
- Short frame: 20 shift codes then PPS -> evrTimestampValid=0, evrSeconds = the shifted 20-bit value zero-extended.
- Disabled or shared codes: heartbeatCode=0 with 0x00 idle stream -> no marker. heartbeatCode=ppsCode=0x7D -> both markers assert on the same edge.
- Reset mid-stretch: assert evrRst_n low while a marker is high -> all outputs 0 immediately. After release, no marker until a new hit.

Source files
------------

// File: rtl/evr_marker_pkg.sv
// Shared constants for the EVR marker decoder: reserved event codes and timestamp width.
package evr_marker_pkg;

  localparam logic [7:0] EVR_CODE_NULL             = 8'h00;
  localparam logic [7:0] EVR_CODE_SHIFT0           = 8'h70;
  localparam logic [7:0] EVR_CODE_SHIFT1           = 8'h71;
  localparam logic [7:0] EVR_CODE_SECONDS_DEFAULT  = 8'h7D;

  localparam int unsigned SECONDS_BITS = 32;

  // A programmed code of 0x00 never matches, so 0 disables that marker.
  function automatic logic code_hit(input logic [7:0] code, input logic [7:0] sel);
    return (code == sel) && (sel != EVR_CODE_NULL);
  endfunction

endpackage

// File: rtl/evr_marker_stretcher.sv
// Stretches a one-cycle hit into a marker MARKER_WIDTH cycles wide.
// Optional holdoff window selected by EVR_MARKER_HOLDOFF_EN.
module evr_marker_stretcher #(
  parameter int unsigned MARKER_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hit,
  output logic marker
);

  localparam logic [7:0] WidthLoad = 8'(MARKER_WIDTH);

  logic [7:0] width_cnt;
  logic       accept;

`ifdef EVR_MARKER_HOLDOFF_EN
  logic [15:0] holdoff;

  // Hits inside the holdoff window are dropped entirely: no reload, no retrigger.
  assign accept = hit && (holdoff == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdoff <= 16'd0;
    end else if (accept) begin
      holdoff <= 16'hFFFF;
    end else if (holdoff != 16'd0) begin
      holdoff <= holdoff - 16'd1;
    end
  end
`else
  assign accept = hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_cnt <= 8'd0;
      marker    <= 1'b0;
    end else begin
      if (accept) begin
        width_cnt <= WidthLoad;
      end else if (width_cnt != 8'd0) begin
        width_cnt <= width_cnt - 8'd1;
      end
      marker <= (width_cnt != 8'd0);
    end
  end

endmodule

// File: rtl/evr_marker_decoder.sv
// EVR event-code decoder: heartbeat/PPS markers plus seconds/ticks timestamp recovery.
// Define EVR_MARKER_HOLDOFF_EN to build per-marker retrigger holdoff.
module evr_marker_decoder
  import evr_marker_pkg::*;
#(
  parameter int unsigned MARKER_WIDTH = 8,
  parameter int unsigned TICKS_WIDTH  = 32
) (
  input  logic                    evrClk,
  input  logic                    evrRst_n,
  input  logic [7:0]              evrEventCode,
  input  logic [7:0]              heartbeatCode,
  input  logic [7:0]              ppsCode,
  output logic                    evrHeartbeatMarker,
  output logic                    evrPulsePerSecondMarker,
  output logic [SECONDS_BITS-1:0] evrSeconds,
  output logic [TICKS_WIDTH-1:0]  evrTicks,
  output logic                    evrTimestampValid,
  output logic                    evrTimestampStrobe
);

  logic [7:0]              code_q;
  logic [SECONDS_BITS-1:0] shift_reg;
  logic [5:0]              bit_count;
  logic                    hb_hit;
  logic                    pps_hit;
  logic                    shift_hit;

  assign hb_hit    = code_hit(code_q, heartbeatCode);
  assign pps_hit   = code_hit(code_q, ppsCode);
  assign shift_hit = (code_q == EVR_CODE_SHIFT0) || (code_q == EVR_CODE_SHIFT1);

  evr_marker_stretcher #(
    .MARKER_WIDTH(MARKER_WIDTH)
  ) u_hb_stretch (
    .clk   (evrClk),
    .rst_n (evrRst_n),
    .hit   (hb_hit),
    .marker(evrHeartbeatMarker)
  );

  evr_marker_stretcher #(
    .MARKER_WIDTH(MARKER_WIDTH)
  ) u_pps_stretch (
    .clk   (evrClk),
    .rst_n (evrRst_n),
    .hit   (pps_hit),
    .marker(evrPulsePerSecondMarker)
  );

  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      code_q             <= 8'd0;
      shift_reg          <= '0;
      bit_count          <= 6'd0;
      evrSeconds         <= '0;
      evrTicks           <= '0;
      evrTimestampValid  <= 1'b0;
      evrTimestampStrobe <= 1'b0;
    end else begin
      code_q             <= evrEventCode;
      evrTimestampStrobe <= pps_hit;
      if (pps_hit) begin
        evrSeconds        <= shift_reg;
        evrTicks          <= '0;
        shift_reg         <= '0;
        bit_count         <= 6'd0;
        evrTimestampValid <= (bit_count == 6'(SECONDS_BITS));
      end else begin
        // A shift code that is also the heartbeat code still feeds the shift register.
        if (shift_hit) begin
          shift_reg <= {shift_reg[SECONDS_BITS-2:0], code_q == EVR_CODE_SHIFT1};
          if (bit_count != 6'(SECONDS_BITS)) begin
            bit_count <= bit_count + 6'd1;
          end
        end
        // A saturated tick count means the PPS was lost; the seconds value is stale.
        if (evrTicks == '1) begin
          evrTimestampValid <= 1'b0;
        end else begin
          evrTicks <= evrTicks + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_evr_marker_decoder.sv
// Directed bench for evr_marker_decoder; expectations are queued with a due edge and checked then.
module tb_evr_marker_decoder;

  localparam int unsigned MW = 8;
  localparam int unsigned TW = 8;

  logic          evrClk = 1'b0;
  logic          evrRst_n = 1'b0;
  logic [7:0]    evrEventCode = 8'h00;
  logic [7:0]    heartbeatCode = 8'h7A;
  logic [7:0]    ppsCode = 8'h7D;
  logic          evrHeartbeatMarker;
  logic          evrPulsePerSecondMarker;
  logic [31:0]   evrSeconds;
  logic [TW-1:0] evrTicks;
  logic          evrTimestampValid;
  logic          evrTimestampStrobe;

  evr_marker_decoder #(
    .MARKER_WIDTH(MW),
    .TICKS_WIDTH (TW)
  ) dut (
    .evrClk                 (evrClk),
    .evrRst_n               (evrRst_n),
    .evrEventCode           (evrEventCode),
    .heartbeatCode          (heartbeatCode),
    .ppsCode                (ppsCode),
    .evrHeartbeatMarker     (evrHeartbeatMarker),
    .evrPulsePerSecondMarker(evrPulsePerSecondMarker),
    .evrSeconds             (evrSeconds),
    .evrTicks               (evrTicks),
    .evrTimestampValid      (evrTimestampValid),
    .evrTimestampStrobe     (evrTimestampStrobe)
  );

  always #5 evrClk = ~evrClk;

  localparam int KHb = 0, KPps = 1, KSec = 2, KTick = 3, KValid = 4, KStrobe = 5;

  typedef struct {
    int unsigned due;
    int          kind;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned edge_n = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      KHb:     return {31'd0, evrHeartbeatMarker};
      KPps:    return {31'd0, evrPulsePerSecondMarker};
      KSec:    return evrSeconds;
      KTick:   return {{(32 - TW){1'b0}}, evrTicks};
      KValid:  return {31'd0, evrTimestampValid};
      default: return {31'd0, evrTimestampStrobe};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int unsigned due, input int kind, input logic [31:0] v,
                           input string tag);
    sb.push_back('{due: due, kind: kind, exp: v, tag: tag});
  endtask

  task automatic check_due();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == edge_n) begin
        check($sformatf("%s@%0d", sb[i].tag, edge_n), observe(sb[i].kind), sb[i].exp);
        sb.delete(i);
      end
    end
  endtask

  task automatic step(input logic [7:0] code);
    evrEventCode = code;
    @(posedge evrClk);
    edge_n++;
    #1;
    check_due();
  endtask

  task automatic idle(input int n);
    repeat (n) step(8'h00);
  endtask

  // Reset pulse between edges; edge numbering is unaffected.
  task automatic pulse_reset();
    evrRst_n = 1'b0;
    #2;
    evrRst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hb"},    {31'd0, evrHeartbeatMarker},      32'd0);
    check({tag, "_pps"},   {31'd0, evrPulsePerSecondMarker}, 32'd0);
    check({tag, "_sec"},   evrSeconds,                       32'd0);
    check({tag, "_ticks"}, {{(32 - TW){1'b0}}, evrTicks},    32'd0);
    check({tag, "_valid"}, {31'd0, evrTimestampValid},       32'd0);
    check({tag, "_strb"},  {31'd0, evrTimestampStrobe},      32'd0);
  endtask

  initial begin
    int unsigned n;
    logic [31:0] word;
    logic [19:0] word20;

    #12;
    check_all_zero("reset");
    evrRst_n = 1'b1;
    idle(3);

    // Single heartbeat: high for edges N+2 .. N+MW+1.
    step(8'h7A);
    n = edge_n;
    expect_at(n + 1, KHb, 0, "hb_single_pre");
    for (int unsigned e = n + 2; e <= n + MW + 1; e++) expect_at(e, KHb, 1, "hb_single");
    expect_at(n + MW + 2, KHb, 0, "hb_single_end");
    expect_at(n + 2, KPps, 0, "hb_single_pps");
    idle(12);

    // Retrigger at N and N+4.
    pulse_reset();
    step(8'h7A);
    n = edge_n;
`ifdef EVR_MARKER_HOLDOFF_EN
    for (int unsigned e = n + 2; e <= n + MW + 1; e++) expect_at(e, KHb, 1, "hb_holdoff");
    for (int unsigned e = n + MW + 2; e <= n + 14; e++) expect_at(e, KHb, 0, "hb_holdoff_lo");
`else
    for (int unsigned e = n + 2; e <= n + MW + 5; e++) expect_at(e, KHb, 1, "hb_retrig");
    expect_at(n + MW + 6, KHb, 0, "hb_retrig_end");
`endif
    idle(3);
    step(8'h7A);
    idle(12);

    // Full 32-bit timestamp frame followed by PPS.
    pulse_reset();
    word = 32'h1234_5678;
    for (int i = 31; i >= 0; i--) step(word[i] ? 8'h71 : 8'h70);
    expect_at(edge_n + 1, KStrobe, 0, "ts_strobe_pre");
    step(8'h7D);
    n = edge_n;
    expect_at(n + 1, KSec,    32'h1234_5678, "ts_sec");
    expect_at(n + 1, KStrobe, 1, "ts_strobe");
    expect_at(n + 1, KValid,  1, "ts_valid");
    expect_at(n + 1, KTick,   0, "ts_ticks0");
    expect_at(n + 2, KStrobe, 0, "ts_strobe_off");
    expect_at(n + 2, KTick,   1, "ts_ticks1");
    expect_at(n + 3, KTick,   2, "ts_ticks2");
    expect_at(n + 3, KSec,    32'h1234_5678, "ts_sec_hold");
    expect_at(n + 2, KPps,    1, "ts_pps_marker");
    // Tick counter saturation invalidates the timestamp.
    expect_at(n + 256, KValid, 1, "sat_valid_pre");
    expect_at(n + 256, KTick, 255, "sat_ticks_max");
    expect_at(n + 257, KValid, 0, "sat_valid_clr");
    expect_at(n + 258, KTick, 255, "sat_ticks_hold");
    idle(260);

    // Short frame of 20 bits.
    word20 = 20'hABCDE;
    for (int i = 19; i >= 0; i--) step(word20[i] ? 8'h71 : 8'h70);
    step(8'h7D);
    n = edge_n;
    expect_at(n + 1, KSec,    32'h000A_BCDE, "short_sec");
    expect_at(n + 1, KValid,  0, "short_valid");
    expect_at(n + 1, KStrobe, 1, "short_strobe");
    idle(12);

    // Disabled heartbeat code on an idle stream.
    pulse_reset();
    heartbeatCode = 8'h00;
    for (int unsigned e = edge_n + 1; e <= edge_n + 10; e++) expect_at(e, KHb, 0, "hb_disabled");
    idle(10);

    // Shared heartbeat/PPS code.
    pulse_reset();
    heartbeatCode = 8'h7D;
    ppsCode = 8'h7D;
    step(8'h7D);
    n = edge_n;
    expect_at(n + 1, KHb,  0, "shared_hb_pre");
    expect_at(n + 1, KPps, 0, "shared_pps_pre");
    expect_at(n + 2, KHb,  1, "shared_hb");
    expect_at(n + 2, KPps, 1, "shared_pps");
    idle(12);

    // Reset while a marker is stretched.
    pulse_reset();
    heartbeatCode = 8'h7A;
    step(8'h7A);
    idle(2);
    check("midrst_hb_high", {31'd0, evrHeartbeatMarker}, 32'd1);
    #2;
    evrRst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    evrRst_n = 1'b1;
    for (int unsigned e = edge_n + 1; e <= edge_n + 12; e++) expect_at(e, KHb, 0, "post_rst_hb");
    idle(12);

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
